alu_exec_unit: RTL and testbench

- Single-issue integer execution unit on the consumer side of the issue-queue issue interface.
- Accepts one selected instruction per cycle via issue_valid/issue_ack and reads its operands from the physical register file.
- Executes single-cycle ALU ops, or an iterative multiply.
- Broadcasts the result on a common data bus (CDB), which drives the issue-queue wake-up, the regfile write and ROB completion.

---
 rtl/alu_exec_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Single-issue integer execution unit: OP stage (ALU / iterative shift-add MUL)
// feeding a RES stage that broadcasts on the CDB with a valid/ready handshake.
module alu_exec_unit #(
  parameter int unsigned PHYS_REG_BITS = 6,
  parameter int unsigned ROB_IDX_BITS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic [3:0]               issue_alu_op,
  input  logic                     issue_alu_src,
  input  logic [31:0]              issue_imm,
  input  logic [PHYS_REG_BITS-1:0] issue_phys_rs1,
  input  logic [PHYS_REG_BITS-1:0] issue_phys_rs2,
  input  logic [PHYS_REG_BITS-1:0] issue_phys_rd,
  input  logic [ROB_IDX_BITS-1:0]  issue_rob_idx,
  output logic                     issue_ack,
  output logic [PHYS_REG_BITS-1:0] rf_raddr1,
  output logic [PHYS_REG_BITS-1:0] rf_raddr2,
  input  logic [31:0]              rf_rdata1,
  input  logic [31:0]              rf_rdata2,
  output logic                     cdb_valid,
  output logic [31:0]              cdb_data,
  output logic [PHYS_REG_BITS-1:0] cdb_phys_rd,
  output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
  input  logic                     cdb_ready,
  output logic                     wakeup_en,
  output logic [PHYS_REG_BITS-1:0] wakeup_phys_rd,
  output logic                     rf_we,
  output logic [PHYS_REG_BITS-1:0] rf_waddr,
  output logic [31:0]              rf_wdata
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_BITS = 5;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(31);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic                     r_op_valid;
  logic [3:0]               r_op;
  logic [XLEN-1:0]          r_a;
  logic [XLEN-1:0]          r_b;
  logic [XLEN-1:0]          r_acc;
  logic [CNT_BITS-1:0]      r_mul_cnt;
  logic [PHYS_REG_BITS-1:0] r_op_rd;
  logic [ROB_IDX_BITS-1:0]  r_op_rob;
  logic                     r_res_valid;
  logic [XLEN-1:0]          r_res_data;
  logic [PHYS_REG_BITS-1:0] r_res_rd;
  logic [ROB_IDX_BITS-1:0]  r_res_rob;

  logic            w_is_mul;
  logic            w_xfer;
  logic            w_res_free;
  logic            w_op_advance;
  logic [XLEN-1:0] w_mul_term;
  logic [XLEN-1:0] w_alu;
  logic [4:0]      w_shamt;

  // Handshake and stage-advance control
  assign w_is_mul     = (r_op == OP_MUL);
  assign cdb_valid    = r_res_valid && !flush;
  assign w_xfer       = cdb_valid && cdb_ready;
  assign w_res_free   = !r_res_valid || w_xfer;
  assign w_op_advance = r_op_valid && w_res_free && (!w_is_mul || (r_mul_cnt == CNT_LAST));
  assign issue_ack    = rst_n && !flush && issue_valid && (!r_op_valid || w_op_advance);

  assign rf_raddr1      = issue_phys_rs1;
  assign rf_raddr2      = issue_phys_rs2;
  assign cdb_data       = r_res_data;
  assign cdb_phys_rd    = r_res_rd;
  assign cdb_rob_idx    = r_res_rob;
  assign wakeup_en      = w_xfer;
  assign wakeup_phys_rd = r_res_rd;
  assign rf_we          = w_xfer && (r_res_rd != '0);
  assign rf_waddr       = r_res_rd;
  assign rf_wdata       = r_res_data;

  assign w_mul_term = r_b[0] ? r_a : '0;
  assign w_shamt    = r_b[4:0];

  // Result mux; MUL folds in the final partial product on its last step
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SLL:  w_alu = r_a << w_shamt;
      OP_SRL:  w_alu = r_a >> w_shamt;
      OP_SRA:  w_alu = XLEN'($signed(r_a) >>> w_shamt);
      OP_SLT:  w_alu = XLEN'($signed(r_a) < $signed(r_b));
      OP_SLTU: w_alu = XLEN'(r_a < r_b);
      OP_MUL:  w_alu = r_acc + w_mul_term;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid  <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_mul_cnt   <= '0;
      r_op_rd     <= '0;
      r_op_rob    <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
      r_res_rob   <= '0;
    end else if (flush) begin
      r_op_valid  <= 1'b0;
      r_res_valid <= 1'b0;
      r_mul_cnt   <= '0;
    end else begin
      if (issue_ack) begin
        r_op_valid <= 1'b1;
        r_op       <= issue_alu_op;
        r_a        <= rf_rdata1;
        r_b        <= issue_alu_src ? issue_imm : rf_rdata2;
        r_op_rd    <= issue_phys_rd;
        r_op_rob   <= issue_rob_idx;
        r_acc      <= '0;
        r_mul_cnt  <= '0;
      end else if (w_op_advance) begin
        r_op_valid <= 1'b0;
        r_mul_cnt  <= '0;
      end else if (r_op_valid && w_is_mul && (r_mul_cnt != CNT_LAST)) begin
        // One shift-add step; holds at the last count while RES is blocked
        r_acc     <= r_acc + w_mul_term;
        r_a       <= r_a << 1;
        r_b       <= r_b >> 1;
        r_mul_cnt <= r_mul_cnt + CNT_BITS'(1);
      end

      if (w_op_advance) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_alu;
        r_res_rd    <= r_op_rd;
        r_res_rob   <= r_op_rob;
      end else if (w_xfer) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for each opcode plus
// hand sequences for latency, back-to-back, backpressure, MUL, flush and reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_alu_op;
  logic        issue_alu_src;
  logic [31:0] issue_imm;
  logic [5:0]  issue_phys_rs1, issue_phys_rs2, issue_phys_rd;
  logic [3:0]  issue_rob_idx;
  logic        issue_ack;
  logic [5:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        cdb_valid;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_phys_rd;
  logic [3:0]  cdb_rob_idx;
  logic        cdb_ready;
  logic        wakeup_en;
  logic [5:0]  wakeup_phys_rd;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [31:0] rf_init [64];

  always #5 clk = ~clk;

  always_comb begin
    rf_rdata1 = rf_init[rf_raddr1];
    rf_rdata2 = rf_init[rf_raddr2];
  end

  alu_exec_unit #(.PHYS_REG_BITS(6), .ROB_IDX_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_alu_op(issue_alu_op), .issue_alu_src(issue_alu_src),
    .issue_imm(issue_imm), .issue_phys_rs1(issue_phys_rs1), .issue_phys_rs2(issue_phys_rs2),
    .issue_phys_rd(issue_phys_rd), .issue_rob_idx(issue_rob_idx), .issue_ack(issue_ack),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_phys_rd(cdb_phys_rd),
    .cdb_rob_idx(cdb_rob_idx), .cdb_ready(cdb_ready), .wakeup_en(wakeup_en),
    .wakeup_phys_rd(wakeup_phys_rd), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic [3:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic src, input logic [5:0] rs1,
                       input logic [5:0] rs2, input logic [31:0] imm,
                       input logic [5:0] rd, input logic [3:0] rob);
    issue_valid    = 1'b1;
    issue_alu_op   = op;
    issue_alu_src  = src;
    issue_phys_rs1 = rs1;
    issue_phys_rs2 = rs2;
    issue_imm      = imm;
    issue_phys_rd  = rd;
    issue_rob_idx  = rob;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic src, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.src = src; v.a = a; v.b = b; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  initial begin
    int cyc;
    int acks;
    int wk;
    logic [31:0] exp3 [3];
    logic [31:0] exp_lat;

    for (int i = 0; i < 64; i++) rf_init[i] = 32'h0;
    rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b1;
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd1, 6'd1, 4'd0);

    vecs[0]  = mk(4'd0,  1'b1, 32'd5,          32'd0,          32'd7, 32'd12);
    vecs[1]  = mk(4'd1,  1'b0, 32'd9,          32'd4,          32'd0, 32'd5);
    vecs[2]  = mk(4'd2,  1'b0, 32'hF0F0_FFFF,  32'h0FF0_00FF,  32'd0, 32'h00F0_00FF);
    vecs[3]  = mk(4'd3,  1'b0, 32'hF000_0000,  32'h0000_000F,  32'd0, 32'hF000_000F);
    vecs[4]  = mk(4'd4,  1'b0, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'd0, 32'hF0F0_0F0F);
    vecs[5]  = mk(4'd5,  1'b0, 32'd1,          32'h23,         32'd0, 32'd8);
    vecs[6]  = mk(4'd6,  1'b1, 32'h8000_0000,  32'd0,          32'd4, 32'h0800_0000);
    vecs[7]  = mk(4'd7,  1'b1, 32'h8000_0000,  32'd0,          32'd4, 32'hF800_0000);
    vecs[8]  = mk(4'd8,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0, 32'd1);
    vecs[9]  = mk(4'd9,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0, 32'd0);
    vecs[10] = mk(4'd9,  1'b0, 32'd1,          32'hFFFF_FFFF,  32'd0, 32'd1);
    vecs[11] = mk(4'd10, 1'b0, 32'h0001_2345,  32'h0000_6789,  32'd0, 32'h75CC_A2ED);
    vecs[12] = mk(4'd10, 1'b1, 32'hFFFF_FFFF,  32'd0,          32'd3, 32'hFFFF_FFFD);
    vecs[13] = mk(4'd12, 1'b0, 32'd7,          32'd9,          32'd0, 32'd0);
    vecs[14] = mk(4'd15, 1'b1, 32'd7,          32'd0,          32'd9, 32'd0);
    vecs[15] = mk(4'd0,  1'b0, 32'hFFFF_FFFF,  32'd2,          32'd0, 32'd1);

    // Reset state, with issue_valid held high to show ack is gated
    repeat (2) @(posedge clk);
    smp();
    chk("rst_ack", 32'(issue_ack), 32'd0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_wakeup", 32'(wakeup_en), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_cdb_data", cdb_data, 32'd0);
    nx();
    rst_n = 1'b1;
    idle();
    nx();

    // Test 1: ADD latency
    rf_init[1] = 32'd5;
    drive(4'd0, 1'b1, 6'd1, 6'd2, 32'd7, 6'd12, 4'd3);
    smp(); chk("t1_ack", 32'(issue_ack), 32'd1);
    nx(); idle();
    smp(); chk("t1_valid_t1", 32'(cdb_valid), 32'd0);
    nx();
    smp();
    chk("t1_valid_t2", 32'(cdb_valid), 32'd1);
    chk("t1_data", cdb_data, 32'd12);
    chk("t1_rd", 32'(cdb_phys_rd), 32'd12);
    chk("t1_rob", 32'(cdb_rob_idx), 32'd3);
    chk("t1_wakeup", 32'(wakeup_en), 32'd1);
    chk("t1_rf_we", 32'(rf_we), 32'd1);
    chk("t1_waddr", 32'(rf_waddr), 32'd12);
    nx();
    smp();
    chk("t1_valid_t3", 32'(cdb_valid), 32'd0);
    chk("t1_wakeup_t3", 32'(wakeup_en), 32'd0);
    nx();

    // Vector table, one instruction at a time
    for (int i = 0; i < NVEC; i++) begin
      rf_init[1] = vecs[i].a;
      rf_init[2] = vecs[i].b;
      drive(vecs[i].op, vecs[i].src, 6'd1, 6'd2, vecs[i].imm, 6'(i + 1), 4'(i));
      smp(); chk("vec_ack", 32'(issue_ack), 32'd1);
      nx(); idle();
      smp();
      cyc = 1;
      while (!cdb_valid && cyc < 40) begin
        nx(); smp(); cyc++;
      end
      exp_lat = (vecs[i].op == 4'd10) ? 32'd33 : 32'd2;
      chk("vec_valid", 32'(cdb_valid), 32'd1);
      chk("vec_latency", 32'(cyc + 1), exp_lat + 32'd1);
      chk("vec_data", cdb_data, vecs[i].exp);
      chk("vec_rd", 32'(cdb_phys_rd), 32'(i + 1));
      chk("vec_rob", 32'(cdb_rob_idx), 32'(i));
      chk("vec_rf_we", 32'(rf_we), 32'd1);
      nx();
    end

    // Test 2: back-to-back SUB, SRA, SLTU
    rf_init[1] = 32'd9; rf_init[2] = 32'd4; rf_init[3] = 32'h8000_0000;
    rf_init[4] = 32'd1; rf_init[5] = 32'hFFFF_FFFF;
    exp3[0] = 32'd5; exp3[1] = 32'hF800_0000; exp3[2] = 32'd1;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(4'd1, 1'b0, 6'd1, 6'd2, 32'd0, 6'd20, 4'd0);
        1: drive(4'd7, 1'b1, 6'd3, 6'd0, 32'd4, 6'd21, 4'd1);
        2: drive(4'd9, 1'b0, 6'd4, 6'd5, 32'd0, 6'd22, 4'd2);
        default: idle();
      endcase
      smp();
      if (c < 3) chk("t2_ack", 32'(issue_ack), 32'd1);
      if (c >= 2 && c <= 4) begin
        chk("t2_valid", 32'(cdb_valid), 32'd1);
        chk("t2_data", cdb_data, exp3[c-2]);
      end
      if (c == 5) chk("t2_valid_end", 32'(cdb_valid), 32'd0);
      nx();
    end

    // Test 3: backpressure with three ADDs
    cdb_ready = 1'b0;
    rf_init[0] = 32'd0;
    exp3[0] = 32'd100; exp3[1] = 32'd101; exp3[2] = 32'd102;
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd100, 6'd30, 4'd5);
    smp(); chk("t3_ack0", 32'(issue_ack), 32'd1);
    nx();
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd101, 6'd31, 4'd6);
    smp(); chk("t3_ack1", 32'(issue_ack), 32'd1);
    nx();
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd102, 6'd32, 4'd7);
    for (int c = 2; c < 5; c++) begin
      smp();
      chk("t3_ack_blocked", 32'(issue_ack), 32'd0);
      chk("t3_hold_valid", 32'(cdb_valid), 32'd1);
      chk("t3_hold_data", cdb_data, 32'd100);
      chk("t3_hold_rd", 32'(cdb_phys_rd), 32'd30);
      chk("t3_no_wakeup", 32'(wakeup_en), 32'd0);
      nx();
    end
    cdb_ready = 1'b1;
    smp(); chk("t3_ack_release", 32'(issue_ack), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("t3_drain_valid", 32'(cdb_valid), 32'd1);
      chk("t3_drain_data", cdb_data, exp3[k]);
      chk("t3_drain_wakeup", 32'(wakeup_en), 32'd1);
      nx(); idle(); smp();
    end
    chk("t3_drain_end", 32'(cdb_valid), 32'd0);
    nx();

    // Test 4: MUL blocks issue until it completes
    rf_init[6] = 32'h0001_2345; rf_init[7] = 32'h0000_6789;
    drive(4'd10, 1'b0, 6'd6, 6'd7, 32'd0, 6'd40, 4'd9);
    smp(); chk("t4_ack", 32'(issue_ack), 32'd1);
    nx();
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd1, 6'd41, 4'd10);
    acks = 0; wk = 0;
    for (int c = 1; c <= 31; c++) begin
      smp();
      if (issue_ack) acks++;
      if (cdb_valid) wk++;
      nx();
    end
    chk("t4_ack_blocked", 32'(acks), 32'd0);
    chk("t4_no_early_cdb", 32'(wk), 32'd0);
    idle();
    smp(); chk("t4_valid_t32", 32'(cdb_valid), 32'd0);
    nx();
    smp();
    chk("t4_valid_t33", 32'(cdb_valid), 32'd1);
    chk("t4_data", cdb_data, 32'h75CC_A2ED);
    chk("t4_rob", 32'(cdb_rob_idx), 32'd9);
    nx();

    // Test 5: flush mid-MUL with a blocked result in RES
    cdb_ready = 1'b0;
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd77, 6'd42, 4'd11);
    nx();
    drive(4'd10, 1'b0, 6'd6, 6'd7, 32'd0, 6'd43, 4'd12);
    smp(); chk("t5_mul_ack", 32'(issue_ack), 32'd1);
    nx();
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd1, 6'd44, 4'd13);
    for (int c = 2; c < 11; c++) nx();
    flush = 1'b1; cdb_ready = 1'b1;
    smp();
    chk("t5_flush_valid", 32'(cdb_valid), 32'd0);
    chk("t5_flush_ack", 32'(issue_ack), 32'd0);
    chk("t5_flush_wakeup", 32'(wakeup_en), 32'd0);
    chk("t5_flush_rf_we", 32'(rf_we), 32'd0);
    nx();
    flush = 1'b0;
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd55, 6'd45, 4'd14);
    wk = 0;
    smp(); chk("t5_new_ack", 32'(issue_ack), 32'd1);
    if (cdb_valid || wakeup_en || rf_we) wk++;
    nx(); idle();
    smp();
    if (cdb_valid || wakeup_en || rf_we) wk++;
    chk("t5_no_stale", 32'(wk), 32'd0);
    nx();
    smp();
    chk("t5_new_valid", 32'(cdb_valid), 32'd1);
    chk("t5_new_data", cdb_data, 32'd55);
    chk("t5_new_rob", 32'(cdb_rob_idx), 32'd14);
    nx();
    smp(); chk("t5_end", 32'(cdb_valid), 32'd0);
    nx();

    // Test 6: async reset with both stages full
    cdb_ready = 1'b0;
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd1, 6'd3, 4'd1);
    nx();
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd2, 6'd4, 4'd2);
    nx();
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd3, 6'd5, 4'd3);
    cdb_ready = 1'b1;
    smp();
    chk("t6_pre_valid", 32'(cdb_valid), 32'd1);
    chk("t6_pre_ack", 32'(issue_ack), 32'd1);
    chk("t6_pre_wakeup", 32'(wakeup_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(cdb_valid), 32'd0);
    chk("t6_rst_ack", 32'(issue_ack), 32'd0);
    chk("t6_rst_wakeup", 32'(wakeup_en), 32'd0);
    chk("t6_rst_rf_we", 32'(rf_we), 32'd0);
    nx();
    rst_n = 1'b1;
    idle();
    nx();
    smp(); chk("t6_post_valid", 32'(cdb_valid), 32'd0);
    nx();

    // Tag 0: broadcast without regfile write
    drive(4'd0, 1'b1, 6'd0, 6'd0, 32'd55, 6'd0, 4'd8);
    smp(); chk("t6_tag0_ack", 32'(issue_ack), 32'd1);
    nx(); idle();
    nx();
    smp();
    chk("t6_tag0_valid", 32'(cdb_valid), 32'd1);
    chk("t6_tag0_data", cdb_data, 32'd55);
    chk("t6_tag0_rf_we", 32'(rf_we), 32'd0);
    chk("t6_tag0_wakeup", 32'(wakeup_en), 32'd1);
    chk("t6_tag0_rob", 32'(cdb_rob_idx), 32'd8);
    nx();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
